// File: rtl/div_req_scheduler_pkg.sv
// Shared constants for the divider request scheduler: FSM encoding, error codes,
// and the operand values that the shift divider cannot handle.
package calc_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [3:0] NEG_MIN = 4'b1000;
    localparam logic [3:0] ZERO4   = 4'b0000;

endpackage

// File: rtl/div_req_scheduler_if.sv
// Request/response channel between the two requesters, the consumer and the scheduler.
// master = requester/consumer side, slave = scheduler side.
interface div_req_scheduler_if;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_q;
    logic [1:0] rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_q, rsp_err
    );
endinterface

// File: rtl/div_req_scheduler_rr_arb2.sv
// Two-port round-robin arbiter; grant is combinational and only offered while en is high.
// The pointer moves to the other port whenever a grant is issued (grant == accept here).
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (|gnt)
            ptr <= ~gnt[1];
    end

endmodule

// File: rtl/div_req_scheduler.sv
// Shares one 4-bit signed divider between two requesters; latency accept->rsp is 14 cycles
// for legal ops, 1 for illegal ops. Requests stall outside IDLE; response holds until rsp_ready.
module div_req_scheduler
    import calc_sched_pkg::*;
#(
    parameter int TIMEOUT = 20,
    parameter int DW      = 4
) (
    input  logic                clk,
    input  logic                rst,
    div_req_scheduler_if.slave  bus,
    output logic                div_start,
    output logic [DW-1:0]       div_a,
    output logic [DW-1:0]       div_b,
    input  logic                div_done,
    input  logic [7:0]          div_q,
    output logic                busy
);

    state_t      state, state_nxt;
    logic [7:0]  timer;
    logic [1:0]  gnt;
    logic        rsp_id_r;
    logic [7:0]  rsp_q_r;
    logic [1:0]  rsp_err_r;
    logic [DW-1:0] sel_a, sel_b;
    logic        accept, illegal, tmo;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  (state == S_IDLE),
        .gnt (gnt)
    );

    assign accept  = |gnt;
    assign sel_a   = gnt[1] ? bus.req_a[7:4] : bus.req_a[3:0];
    assign sel_b   = gnt[1] ? bus.req_b[7:4] : bus.req_b[3:0];
    // The shift divider overflows on -8 and cannot divide by 0 or -8.
    assign illegal = (sel_a == NEG_MIN) || (sel_b == ZERO4) || (sel_b == NEG_MIN);
    assign tmo     = (timer == 8'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = illegal ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (div_done || tmo) state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= 8'd0;
            div_a     <= '0;
            div_b     <= '0;
            rsp_id_r  <= 1'b0;
            rsp_q_r   <= 8'd0;
            rsp_err_r <= ERR_OK;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: if (accept) begin
                    rsp_id_r <= gnt[1];
                    if (illegal) begin
                        rsp_q_r   <= 8'd0;
                        rsp_err_r <= ERR_ILLEGAL;
                    end else begin
                        div_a <= sel_a;
                        div_b <= sel_b;
                    end
                end
                S_ISSUE: timer <= 8'd0;
                S_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (div_done) begin
                        rsp_q_r   <= div_q;
                        rsp_err_r <= ERR_OK;
                    end else if (tmo) begin
                        rsp_q_r   <= 8'd0;
                        rsp_err_r <= ERR_TIMEOUT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_q     = rsp_q_r;
    assign bus.rsp_err   = rsp_err_r;
    assign div_start     = (state == S_ISSUE);
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_div_req_scheduler.sv
// Directed-vector bench for div_req_scheduler with a 12-cycle behavioural divider model.
module tb_div_req_scheduler;

    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       div_start;
    logic [3:0] div_a, div_b;
    logic       div_done;
    logic [7:0] div_q;
    logic       busy;

    logic       hang;
    logic       spur;
    logic [3:0] cnt;
    logic [7:0] mq;

    int n_chk  = 0;
    int n_fail = 0;

    div_req_scheduler_if bus ();

    div_req_scheduler #(.TIMEOUT(TIMEOUT), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Divider model: done pulses 12 cycles after the start cycle.
    always @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
            mq  <= 8'd0;
        end else if (div_start && !hang) begin
            cnt <= 4'd12;
            mq  <= 8'(int'($signed(div_a)) / int'($signed(div_b)));
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end
    assign div_done = (cnt == 4'd1) | spur;
    assign div_q    = mq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outs",
              {bus.req_ready, div_start, div_a, div_b, bus.rsp_valid, bus.rsp_id,
               bus.rsp_q, bus.rsp_err, busy}, 32'd0);
    endtask

    // Present a request, then count cycles from accept until rsp_valid.
    task automatic do_op(input string tag, input logic [1:0] vld,
                         input logic [7:0] a, input logic [7:0] b, input logic [1:0] gnt,
                         input int lat, input logic id, input logic [7:0] q,
                         input logic [1:0] err, input int starts);
        int n;
        int st;
        bit got;
        @(negedge clk);
        bus.req_valid = vld;
        bus.req_a     = a;
        bus.req_b     = b;
        #1;
        check({tag, "_gnt"}, 32'(bus.req_ready), 32'(gnt));
        n = 0; st = 0; got = 0;
        while (n < 100 && !got) begin
            @(negedge clk);
            bus.req_valid = bus.req_valid & ~gnt;
            #1;
            n++;
            if (div_start) st++;
            if (bus.rsp_valid) got = 1;
        end
        check({tag, "_lat"},   32'(n),           32'(lat));
        check({tag, "_start"}, 32'(st),          32'(starts));
        check({tag, "_id"},    32'(bus.rsp_id),  32'(id));
        check({tag, "_q"},     32'(bus.rsp_q),   32'(q));
        check({tag, "_err"},   32'(bus.rsp_err), 32'(err));
    endtask

    initial begin
        bit bad;
        rst = 1'b1;
        hang = 1'b0;
        spur = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a = 8'h00;
        bus.req_b = 8'h00;
        bus.rsp_ready = 1'b1;

        do_reset();
        do_op("p0_6div2", 2'b01, 8'h06, 8'h02, 2'b01, 14, 1'b0, 8'h03, 2'b00, 1);

        // Round-robin with both ports valid from reset: 7/3 on p0, -6/2 on p1.
        do_reset();
        do_op("rr0", 2'b11, 8'hA7, 8'h23, 2'b01, 14, 1'b0, 8'h02, 2'b00, 1);
        do_op("rr1", 2'b11, 8'hA7, 8'h23, 2'b10, 14, 1'b1, 8'hFD, 2'b00, 1);
        do_op("rr2", 2'b11, 8'hA7, 8'h23, 2'b01, 14, 1'b0, 8'h02, 2'b00, 1);
        do_op("rr3", 2'b11, 8'hA7, 8'h23, 2'b10, 14, 1'b1, 8'hFD, 2'b00, 1);

        // Illegal operands short-circuit without starting the divider.
        do_op("ill_b0",  2'b10, 8'h50, 8'h00, 2'b10, 1, 1'b1, 8'h00, 2'b01, 0);
        do_op("ill_a8",  2'b10, 8'h80, 8'h30, 2'b10, 1, 1'b1, 8'h00, 2'b01, 0);
        do_op("ill_b8",  2'b01, 8'h03, 8'h08, 2'b01, 1, 1'b0, 8'h00, 2'b01, 0);

        // Hung divider: abort after TIMEOUT WAIT cycles, then recover.
        hang = 1'b1;
        do_op("tmo", 2'b01, 8'h06, 8'h02, 2'b01, TIMEOUT + 2, 1'b0, 8'h00, 2'b10, 1);
        hang = 1'b0;
        do_op("post_tmo", 2'b10, 8'hA0, 8'h20, 2'b10, 14, 1'b1, 8'hFD, 2'b00, 1);

        // Response backpressure with the other port waiting.
        do_reset();
        bus.rsp_ready = 1'b0;
        do_op("bp_p0", 2'b11, 8'hA7, 8'h23, 2'b01, 14, 1'b0, 8'h02, 2'b00, 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (!bus.rsp_valid || bus.rsp_q != 8'h02 || bus.rsp_id != 1'b0 ||
                bus.req_ready != 2'b00)
                bad = 1;
        end
        check("bp_hold", 32'(bad), 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_rdy_in_resp", 32'(bus.req_ready), 32'd0);
        do_op("bp_p1", 2'b10, 8'hA7, 8'h23, 2'b10, 14, 1'b1, 8'hFD, 2'b00, 1);

        // Reset in WAIT on a p0 op, then a spurious done while idle.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_a = 8'h06;
        bus.req_b = 8'h02;
        #1;
        check("mid_gnt", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        check("mid_busy", 32'({busy, bus.rsp_valid}), 32'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_outs",
              {bus.req_ready, div_start, div_a, div_b, bus.rsp_valid, bus.rsp_id,
               bus.rsp_q, bus.rsp_err, busy}, 32'd0);
        repeat (6) @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid || busy) bad = 1;
        end
        check("spur_ignored", 32'(bad), 32'd0);
        do_op("ptr0", 2'b11, 8'hA7, 8'h23, 2'b01, 14, 1'b0, 8'h02, 2'b00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_req_scheduler.md
Name: div_req_scheduler

Overview:
- Shares the single 4-bit signed shift-division unit between two requesters: the calculator front-end (port 0) and the self-test/replay engine (port 1).
- Arbitrates round-robin and latches operands.
- Issues a one-cycle start pulse and holds operands stable until the divider signals done.
- Returns the 8-bit quotient with requester ID and an error code. Short-circuits illegal operands and guards against a hung divider with a watchdog.

Parameters:
- TIMEOUT, 20, max cycles in WAIT before aborting with timeout error (legal range 13..255).
- DW, 4, operand width (divider fixed at 4; parameter exists only for package constants).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  2  per-requester operation request
- req_ready  out  2  per-requester accept strobe (one-hot or zero)
- req_a  in  8  {a1,a0}, signed 4-bit dividends
- req_b  in  8  {b1,b0}, signed 4-bit divisors
- div_start  out  1  one-cycle start pulse to divider
- div_a  out  4  dividend to divider, held stable ISSUE..end of WAIT
- div_b  out  4  divisor to divider, held stable ISSUE..end of WAIT
- div_done  in  1  divider completion pulse
- div_q  in  8  divider quotient, sign-extended
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_q  out  8  quotient
- rsp_err  out  2  00 ok, 01 illegal operand, 10 timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-high, on clk; it overrides everything including mid-operation.
  - State returns to IDLE; priority pointer is 0.
  - All outputs are 0.
  - A request in flight is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, the arbiter picks a winner.
  - req_ready[winner]=1 combinationally in that same cycle; valid&ready is the transfer.
  - Latch a, b and id.
  - If a==1000, b==0000 or b==1000: go to RESP with rsp_q=0 and rsp_err=01. The divider is not started.
  - Otherwise go to ISSUE.
- Arbitration:
  - A single request always wins.
  - With both requests valid, the port not served last wins; the pointer starts at 0 after reset, so port 0 wins first.
  - The pointer updates on every accept, including illegal-operand accepts.
- ISSUE: div_start=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT:
  - The timer increments each cycle.
  - On div_done: capture div_q into rsp_q, rsp_err=00, go to RESP.
  - If timer reaches TIMEOUT with no done: rsp_q=0, rsp_err=10, go to RESP.
  - If div_done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that transfer go to IDLE. No new accept happens in the same cycle; the earliest next accept is the following cycle.
- div_done outside WAIT is ignored. The divider emits a spurious done about 7 cycles after its own reset.
- div_a/div_b keep their last values in IDLE/RESP. Nominal divider latency is start + 12 cycles; the design makes no assumption about it.
- Throughput:
  - Legal op: accept T, start T+1, done T+13, rsp_valid T+14.
  - Illegal op: rsp_valid T+1.
- req_ready is never asserted outside IDLE. Requesters must hold req_valid and operands until ready.

Decomposition:
- Package calc_sched_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, RESP);
  - ERR_OK/ERR_ILLEGAL/ERR_TIMEOUT;
  - NEG_MIN = 4'b1000;
  - ZERO4.
- Sub-module rr_arb2: 2-input round-robin arbiter with grant-enable and pointer update on accept.
- Illegal-operand check and watchdog stay inline.

Test Plan:
- Port 0 request a=0110 (6), b=0010 (2), rsp_ready=1 -> div_start one cycle after accept; rsp_valid with rsp_id=0, rsp_q=00000011, rsp_err=00.
- Both ports valid from reset: p0 a=0111,b=0011; p1 a=1010 (-6), b=0010 -> p0 served first (q=00000010); then p1 (q=11111101, -3); grants alternate across 4 back-to-back ops.
- Port 1 b=0000 -> no div_start; rsp_valid the next cycle with rsp_q=0, rsp_err=01; the same applies to a=1000 and b=1000.
- Divider model never asserts done -> rsp_valid after exactly TIMEOUT WAIT cycles with rsp_err=10, rsp_q=0; the next request is then serviced normally.
- rsp_ready held low 5 cycles with req_valid pending on the other port -> response stable, req_ready stays 0; after the handshake the other port is accepted the next cycle.
- rst asserted during WAIT; spurious div_done 7 cycles after reset -> all outputs 0, no rsp_valid, state IDLE, pointer 0.
